// File: rtl/preg_memory_ext.sv
// MEM/WB pipeline register: sync reset, stall, flush, valid bit and load-data extraction.
// Define PREG_RETIRE_CNT_EN to add the RetireCountW retired-instruction counter.
module preg_memory_ext #(
    parameter int DATA_WIDTH       = 32,
    parameter int REG_ADDR_WIDTH   = 5,
    parameter int RESULT_SRC_WIDTH = 2,
    parameter int CNT_WIDTH        = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        StallW,
    input  logic                        FlushW,
    input  logic                        ValidM,
    input  logic [DATA_WIDTH-1:0]       ALUResultM,
    input  logic [DATA_WIDTH-1:0]       DMRd,
    input  logic [2:0]                  Funct3M,
    input  logic [REG_ADDR_WIDTH-1:0]   RdM,
    input  logic [DATA_WIDTH-1:0]       PCPlus4M,
    input  logic                        RegWriteM,
    input  logic [RESULT_SRC_WIDTH-1:0] ResultSrcM,
    output logic                        ValidW,
    output logic [DATA_WIDTH-1:0]       ALUResultW,
    output logic [DATA_WIDTH-1:0]       ReadDataW,
    output logic [REG_ADDR_WIDTH-1:0]   RdW,
    output logic [DATA_WIDTH-1:0]       PCPlus4W,
    output logic                        RegWriteW,
    output logic [RESULT_SRC_WIDTH-1:0] ResultSrcW
`ifdef PREG_RETIRE_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]        RetireCountW
`endif
);

    if (DATA_WIDTH < 32 || CNT_WIDTH < 1) begin : g_param_check
        $error("preg_memory_ext: DATA_WIDTH must be >= 32 and CNT_WIDTH >= 1");
    end

    logic                        r_valid;
    logic [DATA_WIDTH-1:0]       r_alu;
    logic [DATA_WIDTH-1:0]       r_rdata;
    logic [REG_ADDR_WIDTH-1:0]   r_rd;
    logic [DATA_WIDTH-1:0]       r_pc4;
    logic                        r_regwrite;
    logic [RESULT_SRC_WIDTH-1:0] r_rsrc;

    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_ext;
    logic                  w_regwrite;
    logic                  w_load;

    // Little-endian lane select; halfword uses only the upper offset bit.
    always_comb begin
        w_byte = DMRd[7:0];
        case (ALUResultM[1:0])
            2'd0: w_byte = DMRd[7:0];
            2'd1: w_byte = DMRd[15:8];
            2'd2: w_byte = DMRd[23:16];
            2'd3: w_byte = DMRd[31:24];
            default: w_byte = DMRd[7:0];
        endcase
        w_half = ALUResultM[1] ? DMRd[31:16] : DMRd[15:0];
    end

    always_comb begin
        w_ext = DMRd;
        case (Funct3M)
            3'b000: w_ext = DATA_WIDTH'($signed(w_byte));
            3'b100: w_ext = DATA_WIDTH'(w_byte);
            3'b001: w_ext = DATA_WIDTH'($signed(w_half));
            3'b101: w_ext = DATA_WIDTH'(w_half);
            3'b010: w_ext = DATA_WIDTH'($signed(DMRd[31:0]));
            3'b110: w_ext = DATA_WIDTH'(DMRd[31:0]);
            default: w_ext = DMRd;
        endcase
    end

    assign w_regwrite = RegWriteM & ValidM & (RdM != '0);
    assign w_load     = !rst && !FlushW && !StallW;

    always_ff @(posedge clk) begin
        if (rst || FlushW) begin
            r_valid    <= 1'b0;
            r_alu      <= '0;
            r_rdata    <= '0;
            r_rd       <= '0;
            r_pc4      <= '0;
            r_regwrite <= 1'b0;
            r_rsrc     <= '0;
        end else if (!StallW) begin
            r_valid    <= ValidM;
            r_alu      <= ALUResultM;
            r_rdata    <= w_ext;
            r_rd       <= RdM;
            r_pc4      <= PCPlus4M;
            r_regwrite <= w_regwrite;
            r_rsrc     <= ResultSrcM;
        end
    end

`ifdef PREG_RETIRE_CNT_EN
    logic [CNT_WIDTH-1:0] r_retire_cnt;

    // Counts only real instructions that actually enter W; wraps naturally.
    always_ff @(posedge clk) begin
        if (rst)
            r_retire_cnt <= '0;
        else if (w_load && ValidM)
            r_retire_cnt <= r_retire_cnt + 1'b1;
    end

    assign RetireCountW = r_retire_cnt;
`else
    logic w_unused_load;
    assign w_unused_load = w_load;
`endif

    assign ValidW     = r_valid;
    assign ALUResultW = r_alu;
    assign ReadDataW  = r_rdata;
    assign RdW        = r_rd;
    assign PCPlus4W   = r_pc4;
    assign RegWriteW  = r_regwrite;
    assign ResultSrcW = r_rsrc;

endmodule

// File: tb/tb_preg_memory_ext.sv
// Bench for preg_memory_ext: table of load/extraction vectors plus stall, flush and reset sequences.
module tb_preg_memory_ext;

    typedef struct packed {
        logic        rst;
        logic        flush;
        logic        stall;
        logic        valid;
        logic [31:0] alu;
        logic [31:0] dmrd;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic        rw;
        logic [1:0]  rs;
    } in_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic        regwrite;
        logic [1:0]  rsrc;
    } out_t;

    typedef struct {
        string name;
        in_t   in;
        out_t  exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, StallW, FlushW, ValidM, RegWriteM;
    logic [31:0] ALUResultM, DMRd, PCPlus4M;
    logic [2:0]  Funct3M;
    logic [4:0]  RdM;
    logic [1:0]  ResultSrcM;
    logic        ValidW, RegWriteW;
    logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
    logic [4:0]  RdW;
    logic [1:0]  ResultSrcW;
`ifdef PREG_RETIRE_CNT_EN
    logic [3:0]  RetireCountW;
`endif

    always #5 clk = ~clk;

    preg_memory_ext #(
        .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .RESULT_SRC_WIDTH(2), .CNT_WIDTH(4)
    ) dut (
        .clk(clk), .rst(rst), .StallW(StallW), .FlushW(FlushW), .ValidM(ValidM),
        .ALUResultM(ALUResultM), .DMRd(DMRd), .Funct3M(Funct3M), .RdM(RdM),
        .PCPlus4M(PCPlus4M), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
        .ValidW(ValidW), .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .RdW(RdW),
        .PCPlus4W(PCPlus4W), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW)
`ifdef PREG_RETIRE_CNT_EN
        , .RetireCountW(RetireCountW)
`endif
    );

    out_t       exp_q[$];
    out_t       m_out;
    logic [3:0] m_cnt;
    int         n_tests = 0;
    int         n_fail  = 0;
    vec_t       tab[$];

    function automatic logic [31:0] ext_model(logic [31:0] d, logic [1:0] off, logic [2:0] f3);
        logic [31:0] s;
        case (f3[1:0])
            2'b00: begin
                s = d >> (8 * off);
                s = f3[2] ? (s & 32'h0000_00FF) : {{24{s[7]}}, s[7:0]};
            end
            2'b01: begin
                s = d >> (16 * off[1]);
                s = f3[2] ? (s & 32'h0000_FFFF) : {{16{s[15]}}, s[15:0]};
            end
            default: s = d;
        endcase
        return s;
    endfunction

    function automatic in_t mk(logic r, logic f, logic s, logic v, logic [31:0] a, logic [31:0] d,
                               logic [2:0] f3, logic [4:0] rd, logic [31:0] pc, logic rw, logic [1:0] rs);
        in_t x;
        x = '{r, f, s, v, a, d, f3, rd, pc, rw, rs};
        return x;
    endfunction

    // Drive inputs and push the caller-supplied expectation for the next edge.
    task automatic drive_exp(input in_t v, input out_t e);
        rst = v.rst; FlushW = v.flush; StallW = v.stall; ValidM = v.valid;
        ALUResultM = v.alu; DMRd = v.dmrd; Funct3M = v.f3; RdM = v.rd;
        PCPlus4M = v.pc4; RegWriteM = v.rw; ResultSrcM = v.rs;
        if (v.rst) m_cnt = '0;
        else if (!v.flush && !v.stall && v.valid) m_cnt = m_cnt + 1'b1;
        m_out = e;
        exp_q.push_back(e);
    endtask

    task automatic drive(input in_t v);
        out_t e;
        e = m_out;
        if (v.rst || v.flush) e = '0;
        else if (!v.stall)
            e = '{v.valid, v.alu, ext_model(v.dmrd, v.alu[1:0], v.f3), v.rd, v.pc4,
                  v.rw & v.valid & (v.rd != 5'd0), v.rs};
        drive_exp(v, e);
    endtask

    task automatic tick(input string nm);
        out_t act, e;
        @(posedge clk);
        #1;
        act = '{ValidW, ALUResultW, ReadDataW, RdW, PCPlus4W, RegWriteW, ResultSrcW};
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, got %h", nm, act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", nm, act, e);
            end
        end
`ifdef PREG_RETIRE_CNT_EN
        n_tests++;
        if (RetireCountW !== m_cnt) begin
            n_fail++;
            $display("FAIL %s_cnt: got %h expected %h", nm, RetireCountW, m_cnt);
        end
`endif
    endtask

    task automatic step(input in_t v, input string nm);
        drive(v);
        tick(nm);
    endtask

    in_t idle;

    initial begin
        m_out = '0;
        m_cnt = '0;
        idle  = mk(0, 0, 0, 0, 32'h0, 32'h0, 3'b000, 5'd0, 32'h0, 0, 2'b00);

        tab.push_back('{"reset0", mk(1,0,0,1,32'h1111_1111,32'h2222_2222,3'b010,5'h3,32'h4,1,2'b01), '0});
        tab.push_back('{"reset1", mk(1,0,0,1,32'h1111_1111,32'h2222_2222,3'b010,5'h3,32'h4,1,2'b01), '0});
        tab.push_back('{"basic_lw", mk(0,0,0,1,32'hDEADBEEC,32'hCAFEBABE,3'b010,5'h1F,32'hABCDEF01,1,2'b01),
                       '{1'b1,32'hDEADBEEC,32'hCAFEBABE,5'h1F,32'hABCDEF01,1'b1,2'b01}});
        tab.push_back('{"lb_off0", mk(0,0,0,1,32'h100,32'h80F07F81,3'b000,5'h3,32'h8,1,2'b01),
                       '{1'b1,32'h100,32'hFFFFFF81,5'h3,32'h8,1'b1,2'b01}});
        tab.push_back('{"lbu_off1", mk(0,0,0,1,32'h101,32'h80F07F81,3'b100,5'h3,32'h8,1,2'b01),
                       '{1'b1,32'h101,32'h0000007F,5'h3,32'h8,1'b1,2'b01}});
        tab.push_back('{"lh_off2", mk(0,0,0,1,32'h102,32'h80F07F81,3'b001,5'h3,32'h8,1,2'b01),
                       '{1'b1,32'h102,32'hFFFF80F0,5'h3,32'h8,1'b1,2'b01}});
        tab.push_back('{"lhu_off3", mk(0,0,0,1,32'h103,32'h80F07F81,3'b101,5'h3,32'h8,1,2'b01),
                       '{1'b1,32'h103,32'h000080F0,5'h3,32'h8,1'b1,2'b01}});
        tab.push_back('{"lb_off3", mk(0,0,0,1,32'h103,32'h80F07F81,3'b000,5'h4,32'hC,1,2'b10),
                       '{1'b1,32'h103,32'hFFFFFF80,5'h4,32'hC,1'b1,2'b10}});
        tab.push_back('{"lbu_off2", mk(0,0,0,1,32'h102,32'h80F07F81,3'b100,5'h4,32'hC,1,2'b01),
                       '{1'b1,32'h102,32'h000000F0,5'h4,32'hC,1'b1,2'b01}});
        tab.push_back('{"lh_off1", mk(0,0,0,1,32'h101,32'h80F07F81,3'b001,5'h4,32'hC,1,2'b01),
                       '{1'b1,32'h101,32'h00007F81,5'h4,32'hC,1'b1,2'b01}});
        tab.push_back('{"lwu", mk(0,0,0,1,32'h7,32'h80F07F81,3'b110,5'h6,32'h10,1,2'b01),
                       '{1'b1,32'h7,32'h80F07F81,5'h6,32'h10,1'b1,2'b01}});
        tab.push_back('{"pass011", mk(0,0,0,1,32'h5,32'h12345678,3'b011,5'h7,32'h14,0,2'b00),
                       '{1'b1,32'h5,32'h12345678,5'h7,32'h14,1'b0,2'b00}});
        tab.push_back('{"pass111", mk(0,0,0,1,32'h6,32'h89ABCDEF,3'b111,5'h8,32'h18,1,2'b11),
                       '{1'b1,32'h6,32'h89ABCDEF,5'h8,32'h18,1'b1,2'b11}});
        tab.push_back('{"x0_write", mk(0,0,0,1,32'h20,32'h0000FFFF,3'b010,5'h0,32'h1C,1,2'b00),
                       '{1'b1,32'h20,32'h0000FFFF,5'h0,32'h1C,1'b0,2'b00}});
        tab.push_back('{"invalid_wr", mk(0,0,0,0,32'h24,32'h0000FFFF,3'b010,5'h5,32'h20,1,2'b00),
                       '{1'b0,32'h24,32'h0000FFFF,5'h5,32'h20,1'b0,2'b00}});

        foreach (tab[i]) begin
            drive_exp(tab[i].in, tab[i].exp);
            tick(tab[i].name);
        end

        // Stall holds A for three edges while inputs move to B.
        step(mk(0,0,0,1,32'hA0A0_A0A0,32'h1111_2222,3'b010,5'h0A,32'hA4,1,2'b01), "load_A");
        for (int k = 0; k < 3; k++)
            step(mk(0,0,1,1,32'hB0B0_B0B1,32'h3344_5566,3'b100,5'h0B,32'hB4,1,2'b10), "stall_hold_A");
        step(mk(0,0,0,1,32'hB0B0_B0B1,32'h3344_5566,3'b100,5'h0B,32'hB4,1,2'b10), "load_B");
        step(mk(0,1,1,1,32'hC0C0_C0C0,32'h7777_8888,3'b010,5'h0C,32'hC4,1,2'b01), "flush_stall");
        step(mk(0,0,0,1,32'hD0D0_D0D2,32'h9ABC_DEF0,3'b001,5'h0D,32'hD4,1,2'b11), "load_after_flush");

        // Reset during an active stall that is holding nonzero data.
        step(mk(0,0,1,1,32'hE0E0_E0E0,32'h1,3'b010,5'h0E,32'hE4,1,2'b01), "stall_before_rst");
        step(mk(1,0,1,1,32'hE0E0_E0E0,32'h1,3'b010,5'h0E,32'hE4,1,2'b01), "rst_mid_stall");
        step(mk(1,1,0,1,32'hE0E0_E0E0,32'h1,3'b010,5'h0E,32'hE4,1,2'b01), "rst_held");
        step(mk(0,0,0,1,32'hF0F0_F0F3,32'hFF00_7F00,3'b000,5'h0F,32'hF4,1,2'b01), "load_after_rst");

        // 20 valid loads interleaved with 3 stalls and 2 flushes; count wraps to 4.
        step(mk(1,0,0,0,32'h0,32'h0,3'b000,5'h0,32'h0,0,2'b00), "cnt_rst");
        for (int k = 0; k < 20; k++) begin
            if (k == 4 || k == 9 || k == 14)
                step(mk(0,0,1,1,32'h40 + k,32'hABCD_0000 + k,3'b010,5'h1,32'h200,1,2'b00), "cnt_stall");
            if (k == 7 || k == 16)
                step(mk(0,1,0,1,32'h80 + k,32'h1234_0000 + k,3'b010,5'h2,32'h300,1,2'b00), "cnt_flush");
            step(mk(0,0,0,1,32'h100 + 4 * k,32'h5A5A_0000 + k,3'b010,5'(k + 1),32'h400 + k,1,2'b01), "cnt_load");
        end
`ifdef PREG_RETIRE_CNT_EN
        n_tests++;
        if (RetireCountW !== 4'h4) begin
            n_fail++;
            $display("FAIL retire_wrap: got %h expected %h", RetireCountW, 4'h4);
        end
`endif
        step(mk(1,0,0,1,32'h1,32'h1,3'b010,5'h1,32'h1,1,2'b01), "cnt_clear_rst");
`ifdef PREG_RETIRE_CNT_EN
        n_tests++;
        if (RetireCountW !== 4'h0) begin
            n_fail++;
            $display("FAIL retire_clear: got %h expected %h", RetireCountW, 4'h0);
        end
`endif
        step(idle, "idle_load");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/preg_memory_ext.md
# preg_memory_ext

Parametrised MEM/WB pipeline register for the RV32I pipeline with synchronous reset, stall (hold), flush (bubble insertion), and a valid bit. Load-data byte/halfword extraction and sign/zero extension move from the writeback mux into this stage. Sits between data memory and the writeback result mux and register file. Adds an optional retired-instruction counter.

## Interface
- DATA_WIDTH, 32, datapath width; must be ≥ 32
- REG_ADDR_WIDTH, 5, register-file address width
- RESULT_SRC_WIDTH, 2, width of result-select field
- CNT_WIDTH, 32, retire counter width (used only with PREG_RETIRE_CNT_EN)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- StallW  in  1  hold all W-side state this cycle
- FlushW  in  1  insert bubble this cycle
- ValidM  in  1  M-stage holds a real instruction
- ALUResultM  in  DATA_WIDTH  ALU result / memory address
- DMRd  in  DATA_WIDTH  raw data-memory read word
- Funct3M  in  3  load type
- RdM  in  REG_ADDR_WIDTH  destination register
- PCPlus4M  in  DATA_WIDTH  PC+4
- RegWriteM  in  1  register write request
- ResultSrcM  in  RESULT_SRC_WIDTH  result select
- ValidW  out  1  W-stage valid
- ALUResultW  out  DATA_WIDTH  registered ALU result
- ReadDataW  out  DATA_WIDTH  extracted, extended load data
- RdW  out  REG_ADDR_WIDTH  registered destination
- PCPlus4W  out  DATA_WIDTH  registered PC+4
- RegWriteW  out  1  qualified write enable
- ResultSrcW  out  RESULT_SRC_WIDTH  registered result select
- RetireCountW  out  CNT_WIDTH  retired count (present only with PREG_RETIRE_CNT_EN)

## Operation
- Per-edge priority: rst > FlushW > StallW > load.
- rst or FlushW: every W output and internal register is set to 0, including ValidW, RegWriteW, RdW, and the data fields.
- StallW (without flush or reset): all registers hold their value.
- Load: each M field is captured into its W counterpart. ValidW is set to ValidM.
- RegWriteW is captured as RegWriteM & ValidM & (RdM != 0). Writes to x0 and bubbles never assert it.
- ReadDataW is computed combinationally from DMRd, Funct3M, and off = ALUResultM[1:0], then registered:
  - 000 LB: byte[off], sign-extended to DATA_WIDTH
  - 100 LBU: byte[off], zero-extended
  - 001 LH: halfword[off[1]], sign-extended; off[0] is ignored
  - 101 LHU: halfword[off[1]], zero-extended; off[0] is ignored
  - 010 LW: DMRd[31:0], sign-extended from bit 31; off is ignored
  - 110 LWU: DMRd[31:0], zero-extended
  - 011, 111: DMRd passes through unchanged
- The byte lane is little-endian: byte[k] = DMRd[8k+7:8k].
- Extraction is applied even when ResultSrcM does not select memory. The writeback mux ignores it.

## Timing
- Latency is one cycle from M inputs to W outputs.
- No combinational path from any input to any output.
- Reset value of every output is 0, including RetireCountW.
- Stall lasting N cycles: outputs are held for N cycles, then load resumes on the first edge with StallW=0.
- FlushW and StallW together: the flush wins and the bubble is inserted.
- rst asserted mid-stall or mid-flush: the stage clears on that edge. Outputs stay 0 while rst is held.
- After rst is released, the first edge loads the M inputs normally.

## Configuration
- PREG_RETIRE_CNT_EN defined:
  - RetireCountW port exists.
  - The counter increments by 1 on each edge where the stage loads (no rst, FlushW, or StallW) with ValidM=1.
  - It wraps modulo 2^CNT_WIDTH.
  - It holds its value on stall and flush and clears on rst.
  - Its output is registered and reflects instructions loaded up to and including the previous edge.
- PREG_RETIRE_CNT_EN undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset then basic load: assert rst for 2 cycles, then release.
  - During reset all outputs are 0.
  - Then drive ALUResultM=32'hDEADBEEC, DMRd=32'hCAFEBABE, Funct3M=010, RdM=5'h1F, PCPlus4M=32'hABCDEF01, RegWriteM=1, ResultSrcM=2'b01, ValidM=1.
  - Next edge: ReadDataW=32'hCAFEBABE, RdW=5'h1F, RegWriteW=1, ValidW=1.
- Load extraction with DMRd=32'h80F0_7F81:
  - LB, off=0 → ReadDataW=32'hFFFFFF81
  - LBU, off=1 → 32'h0000007F
  - LH, off=2 → 32'hFFFF80F0
  - LHU, off=3 → 32'h000080F0
- Stall and flush:
  - Load A, then hold StallW=1 for 3 cycles while the inputs change to B. Outputs stay A.
  - Drop StallW: outputs become B on the next edge.
  - Assert FlushW and StallW together: ValidW=0, RegWriteW=0, RdW=0.
- Write qualification:
  - RdM=0 with RegWriteM=1, ValidM=1 → RegWriteW=0.
  - RdM=5'h05 with RegWriteM=1, ValidM=0 → RegWriteW=0, ValidW=0.
- Reset mid-stall: during an active stall holding nonzero data, assert rst for 1 cycle. All outputs are 0 on that edge.
- Retire counter (PREG_RETIRE_CNT_EN, CNT_WIDTH=4):
  - Drive 20 valid loads interleaved with 3 stalls and 2 flushes. RetireCountW=4'h4, since 20 mod 16 = 4.
  - A following rst clears it to 0.
